// File: rtl/ocx_tlx_framer_cmd_sched.sv
// Credit-gated command scheduler between the TL command FIFO and the flit packer.
// Optional stall watchdog enabled by defining OCX_TLX_FRAMER_CMD_STALL_TIMER_EN.
module ocx_tlx_framer_cmd_sched #(
  parameter int INIT_CREDITS = 8,
  parameter int CREDIT_MAX   = 16,
  parameter int STALL_LIMIT  = 255
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         fifo_data_available,
  input  logic [171:0] fifo_data,
  output logic         fifo_rd_done,
  input  logic         crd_return_valid,
  input  logic [3:0]   crd_return_count,
  output logic         cmd_valid,
  output logic [171:0] cmd_data,
  input  logic         cmd_ready,
  output logic [4:0]   credit_count,
  output logic [15:0]  sent_count,
  output logic         credit_overflow_error,
  output logic         stall_error
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [5:0] CREDIT_CEIL = 6'(CREDIT_MAX);
  localparam logic [4:0] CREDIT_INIT = 5'(INIT_CREDITS);

  state_t     state;
  state_t     state_nxt;
  logic       load;
  logic [5:0] credit_sum;

  assign cmd_valid = (state == HOLD);

  // Load decision, pop strobe, next state and next credit value.
  always_comb begin
    load         = 1'b0;
    fifo_rd_done = 1'b0;
    state_nxt    = state;
    credit_sum   = 6'd0;
    load = fifo_data_available && (credit_count != 5'd0) && ((state == IDLE) || cmd_ready);
    fifo_rd_done = load && reset_n;
    case (state)
      IDLE: begin
        if (load) state_nxt = HOLD;
        else      state_nxt = IDLE;
      end
      HOLD: begin
        if (load)           state_nxt = HOLD;
        else if (cmd_ready) state_nxt = IDLE;
        else                state_nxt = HOLD;
      end
      default: state_nxt = IDLE;
    endcase
    // load implies credit_count > 0, so the subtraction never underflows.
    if (crd_return_valid) begin
      credit_sum = {1'b0, credit_count} - {5'd0, load} + {2'd0, crd_return_count};
    end else begin
      credit_sum = {1'b0, credit_count} - {5'd0, load};
    end
  end

  // State, held command, credit and sent-count registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state                 <= IDLE;
      cmd_data              <= 172'd0;
      credit_count          <= CREDIT_INIT;
      sent_count            <= 16'd0;
      credit_overflow_error <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) cmd_data <= fifo_data;
      if (credit_sum > CREDIT_CEIL) begin
        credit_count          <= CREDIT_CEIL[4:0];
        credit_overflow_error <= 1'b1;
      end else begin
        credit_count          <= credit_sum[4:0];
        credit_overflow_error <= 1'b0;
      end
      if (cmd_valid && cmd_ready) sent_count <= sent_count + 16'd1;
    end
  end

`ifdef OCX_TLX_FRAMER_CMD_STALL_TIMER_EN
  localparam logic [7:0] STALL_THRESH = 8'(STALL_LIMIT);

  logic [7:0] stall_cnt;

  // Consecutive back-pressure cycles, saturating so a long stall keeps the error up.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_cnt <= 8'd0;
    end else if ((state == IDLE) || cmd_ready) begin
      stall_cnt <= 8'd0;
    end else if (stall_cnt != 8'hFF) begin
      stall_cnt <= stall_cnt + 8'd1;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

  assign stall_error = (stall_cnt >= STALL_THRESH);
`else
  assign stall_error = 1'b0;
`endif

endmodule

// File: tb/tb_ocx_tlx_framer_cmd_sched.sv
// Directed bench for ocx_tlx_framer_cmd_sched: FIFO model feeds a scoreboard of
// expected commands that is checked at every packer handshake.
module tb_ocx_tlx_framer_cmd_sched;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         fifo_data_available;
  logic [171:0] fifo_data;
  logic         fifo_rd_done;
  logic         crd_return_valid;
  logic [3:0]   crd_return_count;
  logic         cmd_valid;
  logic [171:0] cmd_data;
  logic         cmd_ready;
  logic [4:0]   credit_count;
  logic [15:0]  sent_count;
  logic         credit_overflow_error;
  logic         stall_error;

  int tests = 0;
  int fails = 0;
  logic [171:0] fq[$];
  logic [171:0] exp_q[$];

  ocx_tlx_framer_cmd_sched dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .fifo_data_available   (fifo_data_available),
    .fifo_data             (fifo_data),
    .fifo_rd_done          (fifo_rd_done),
    .crd_return_valid      (crd_return_valid),
    .crd_return_count      (crd_return_count),
    .cmd_valid             (cmd_valid),
    .cmd_data              (cmd_data),
    .cmd_ready             (cmd_ready),
    .credit_count          (credit_count),
    .sent_count            (sent_count),
    .credit_overflow_error (credit_overflow_error),
    .stall_error           (stall_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [171:0] obs, input logic [171:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive_fifo();
    fifo_data_available = (fq.size() > 0);
    fifo_data           = (fq.size() > 0) ? fq[0] : 172'd0;
  endtask

  task automatic push(input int k);
    logic [171:0] e;
    e = {12'(k), $urandom, $urandom, $urandom, $urandom, $urandom};
    fq.push_back(e);
    drive_fifo();
  endtask

  // One clock: check pop strobe and handshake data before the edge, update models after.
  task automatic tick(input bit chk_rd, input bit exp_rd);
    logic popped;
    #1;
    popped = fifo_rd_done;
    if (chk_rd) chk("rd_done", 172'(fifo_rd_done), 172'(exp_rd));
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      tests++;
      assert (exp_q.size() > 0) else begin
        fails++;
        $error("FAIL sb_underflow observed=handshake expected=no_handshake");
      end
      if (exp_q.size() > 0) chk("cmd_data_sb", cmd_data, exp_q.pop_front());
    end
    @(posedge clock);
    #1;
    if (popped === 1'b1 && fq.size() > 0) exp_q.push_back(fq.pop_front());
    drive_fifo();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [171:0] a0, a1, a2, h, r1;
    bit exp_st;

    reset_n          = 1'b0;
    cmd_ready        = 1'b0;
    crd_return_valid = 1'b0;
    crd_return_count = 4'd0;
    push(0);
    @(negedge clock);

    // Reset with FIFO non-empty: no pop, all state at reset values.
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("rst_cmd_valid", 172'(cmd_valid), 172'(0));
    chk("rst_cmd_data", cmd_data, 172'd0);
    chk("rst_credit", 172'(credit_count), 172'(8));
    chk("rst_sent", 172'(sent_count), 172'(0));
    chk("rst_ovf", 172'(credit_overflow_error), 172'(0));
    chk("rst_stall", 172'(stall_error), 172'(0));

    // Three entries back to back.
    push(1);
    push(2);
    a0 = fq[0];
    a1 = fq[1];
    a2 = fq[2];
    reset_n   = 1'b1;
    cmd_ready = 1'b1;
    tick(1'b1, 1'b1);
    chk("lat_valid", 172'(cmd_valid), 172'(1));
    chk("lat_data0", cmd_data, a0);
    tick(1'b1, 1'b1);
    chk("lat_data1", cmd_data, a1);
    tick(1'b1, 1'b1);
    chk("lat_data2", cmd_data, a2);
    tick(1'b1, 1'b0);
    chk("b2b_valid", 172'(cmd_valid), 172'(0));
    chk("b2b_credit", 172'(credit_count), 172'(5));
    chk("b2b_sent", 172'(sent_count), 172'(3));

    // Back-pressure for 10 cycles in HOLD.
    cmd_ready = 1'b0;
    push(3);
    push(4);
    h = fq[0];
    tick(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0);
      chk("hold_data", cmd_data, h);
    end
    chk("hold_valid", 172'(cmd_valid), 172'(1));
    chk("hold_sent", 172'(sent_count), 172'(3));
    chk("hold_credit", 172'(credit_count), 172'(4));
    cmd_ready = 1'b1;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    chk("release_sent", 172'(sent_count), 172'(5));
    chk("release_credit", 172'(credit_count), 172'(3));

    // Credit exhaustion with FIFO still non-empty, then refill by return.
    for (int k = 10; k < 15; k++) push(k);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("exhaust_credit", 172'(credit_count), 172'(0));
    chk("exhaust_valid", 172'(cmd_valid), 172'(0));
    chk("exhaust_sent", 172'(sent_count), 172'(8));
    crd_return_valid = 1'b1;
    crd_return_count = 4'd2;
    tick(1'b1, 1'b0);
    crd_return_valid = 1'b0;
    chk("return_credit", 172'(credit_count), 172'(2));
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    chk("refill_credit", 172'(credit_count), 172'(0));
    chk("refill_sent", 172'(sent_count), 172'(10));
    chk("refill_drained", 172'(fq.size()), 172'(0));

    // Overflow: 10 credits, return 9 together with a load.
    crd_return_valid = 1'b1;
    crd_return_count = 4'd10;
    tick(1'b1, 1'b0);
    chk("pre_ovf_credit", 172'(credit_count), 172'(10));
    chk("pre_ovf_flag", 172'(credit_overflow_error), 172'(0));
    push(20);
    crd_return_count = 4'd9;
    tick(1'b1, 1'b1);
    crd_return_valid = 1'b0;
    chk("ovf_credit", 172'(credit_count), 172'(16));
    chk("ovf_flag", 172'(credit_overflow_error), 172'(1));
    tick(1'b1, 1'b0);
    chk("ovf_pulse_end", 172'(credit_overflow_error), 172'(0));
    chk("ovf_credit_hold", 172'(credit_count), 172'(16));
    chk("ovf_sent", 172'(sent_count), 172'(11));

    // Reset while holding a command.
    cmd_ready = 1'b0;
    push(30);
    push(31);
    r1 = fq[1];
    tick(1'b1, 1'b1);
    chk("midrst_hold", 172'(cmd_valid), 172'(1));
    reset_n = 1'b0;
    tick(1'b1, 1'b0);
    exp_q.delete();
    chk("midrst_valid", 172'(cmd_valid), 172'(0));
    chk("midrst_credit", 172'(credit_count), 172'(8));
    chk("midrst_sent", 172'(sent_count), 172'(0));
    chk("midrst_data", cmd_data, 172'd0);
    reset_n   = 1'b1;
    cmd_ready = 1'b1;
    tick(1'b1, 1'b1);
    chk("postrst_data", cmd_data, r1);
    tick(1'b1, 1'b0);
    chk("postrst_sent", 172'(sent_count), 172'(1));
    chk("postrst_credit", 172'(credit_count), 172'(7));

    // Long stall: watchdog behaviour depends on build option.
    cmd_ready = 1'b0;
    push(40);
    tick(1'b1, 1'b1);
    for (int i = 1; i <= 260; i++) begin
      tick(1'b0, 1'b0);
`ifdef OCX_TLX_FRAMER_CMD_STALL_TIMER_EN
      exp_st = (i >= 255);
`else
      exp_st = 1'b0;
`endif
      chk($sformatf("stall_c%0d", i), 172'(stall_error), 172'(exp_st));
    end
    cmd_ready = 1'b1;
    tick(1'b1, 1'b0);
    chk("stall_clear", 172'(stall_error), 172'(0));
    chk("stall_sent", 172'(sent_count), 172'(2));
    chk("sb_empty", 172'(exp_q.size()), 172'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
